// File: rtl/match_turn_controller.sv
// match_turn_controller: turn sequencer for the two-player card-matching game.
// Pairs two card flips per turn, scores matches for the active player, runs
// the per-turn countdown, passes the turn on mismatch or timeout and ends the
// game once every pair has been matched. All outputs are registered.
//
// Ports:
//   clock, reset_n         system clock, synchronous active-low reset
//   start                  pulse, begins a new game from IDLE or DONE
//   tick                   1 Hz enable for the turn timer and mismatch hold
//   flip_valid/index/value card flip request from the board
//   flip_ready             flips accepted (FIRST/SECOND)
//   turn                   active player, 0 = P1, 1 = P2
//   p1_score, p2_score     player scores (wrap modulo 2^SCORE_W)
//   timer, pairs_left      remaining seconds of the turn, unmatched pairs
//   match/mismatch/timeout_pulse  one-cycle event strobes
//   game_over              high in DONE
//
// Build option: define MATCH_BONUS_EN to award 2 points for a match evaluated
// while the timer is still in the upper half of the turn.
module match_turn_controller #(
   parameter int unsigned TURN_SECONDS = 9,
   parameter int unsigned HOLD_TICKS   = 2,
   parameter int unsigned NUM_PAIRS    = 8,
   parameter int unsigned SCORE_W      = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               tick,
   input  logic               flip_valid,
   input  logic [3:0]         flip_index,
   input  logic [3:0]         flip_value,
   output logic               flip_ready,
   output logic               turn,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [3:0]         timer,
   output logic [3:0]         pairs_left,
   output logic               match_pulse,
   output logic               mismatch_pulse,
   output logic               timeout_pulse,
   output logic               game_over
);

   localparam logic [3:0] TIMER_RELOAD = 4'(TURN_SECONDS);
   localparam logic [3:0] HOLD_RELOAD  = 4'(HOLD_TICKS);
   localparam logic [3:0] PAIRS_RELOAD = 4'(NUM_PAIRS);
`ifdef MATCH_BONUS_EN
   localparam logic [3:0] BONUS_MIN    = 4'((TURN_SECONDS + 1) / 2);
`endif

   typedef enum logic [2:0] {IDLE, FIRST, SECOND, EVAL, HOLD, DONE} state_t;

   state_t             state, state_nxt;
   logic [3:0]         a_index, a_index_nxt;
   logic [3:0]         a_value, a_value_nxt;
   logic [3:0]         b_value, b_value_nxt;
   logic [3:0]         hold_cnt, hold_cnt_nxt;
   logic               turn_nxt;
   logic [SCORE_W-1:0] p1_score_nxt, p2_score_nxt, gain;
   logic [3:0]         timer_nxt, pairs_left_nxt, timer_dec;
   logic               match_nxt, mismatch_nxt, timeout_nxt;
   logic               flip_ready_nxt, game_over_nxt;
   logic               accept;

   // State and output registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         a_index        <= 4'd0;
         a_value        <= 4'd0;
         b_value        <= 4'd0;
         hold_cnt       <= 4'd0;
         turn           <= 1'b0;
         p1_score       <= '0;
         p2_score       <= '0;
         timer          <= 4'd0;
         pairs_left     <= PAIRS_RELOAD;
         match_pulse    <= 1'b0;
         mismatch_pulse <= 1'b0;
         timeout_pulse  <= 1'b0;
         flip_ready     <= 1'b0;
         game_over      <= 1'b0;
      end else begin
         state          <= state_nxt;
         a_index        <= a_index_nxt;
         a_value        <= a_value_nxt;
         b_value        <= b_value_nxt;
         hold_cnt       <= hold_cnt_nxt;
         turn           <= turn_nxt;
         p1_score       <= p1_score_nxt;
         p2_score       <= p2_score_nxt;
         timer          <= timer_nxt;
         pairs_left     <= pairs_left_nxt;
         match_pulse    <= match_nxt;
         mismatch_pulse <= mismatch_nxt;
         timeout_pulse  <= timeout_nxt;
         flip_ready     <= flip_ready_nxt;
         game_over      <= game_over_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt      = state;
      a_index_nxt    = a_index;
      a_value_nxt    = a_value;
      b_value_nxt    = b_value;
      hold_cnt_nxt   = hold_cnt;
      turn_nxt       = turn;
      p1_score_nxt   = p1_score;
      p2_score_nxt   = p2_score;
      timer_nxt      = timer;
      pairs_left_nxt = pairs_left;
      match_nxt      = 1'b0;
      mismatch_nxt   = 1'b0;
      timeout_nxt    = 1'b0;

      // flip_ready mirrors FIRST/SECOND, so it doubles as the accept qualifier
      accept    = flip_valid && flip_ready;
      timer_dec = timer - 4'd1;
`ifdef MATCH_BONUS_EN
      gain = (timer >= BONUS_MIN) ? SCORE_W'(2) : SCORE_W'(1);
`else
      gain = SCORE_W'(1);
`endif

      case (state)
         IDLE, DONE: begin
            if (start) begin
               p1_score_nxt   = '0;
               p2_score_nxt   = '0;
               pairs_left_nxt = PAIRS_RELOAD;
               turn_nxt       = 1'b0;
               timer_nxt      = TIMER_RELOAD;
               state_nxt      = FIRST;
            end
         end
         FIRST: begin
            if (tick) timer_nxt = timer_dec;
            // An expiring tick discards the turn even if a first card arrives
            if (tick && timer_dec == 4'd0) begin
               timeout_nxt = 1'b1;
               turn_nxt    = ~turn;
               timer_nxt   = TIMER_RELOAD;
            end else if (accept) begin
               a_index_nxt = flip_index;
               a_value_nxt = flip_value;
               state_nxt   = SECOND;
            end
         end
         SECOND: begin
            if (tick) timer_nxt = timer_dec;
            // A valid second card beats a simultaneous expiring tick
            if (accept && flip_index != a_index) begin
               b_value_nxt = flip_value;
               state_nxt   = EVAL;
            end else if (tick && timer_dec == 4'd0) begin
               timeout_nxt = 1'b1;
               turn_nxt    = ~turn;
               timer_nxt   = TIMER_RELOAD;
               state_nxt   = FIRST;
            end
         end
         EVAL: begin
            if (a_value == b_value) begin
               match_nxt = 1'b1;
               if (turn) p2_score_nxt = p2_score + gain;
               else      p1_score_nxt = p1_score + gain;
               pairs_left_nxt = pairs_left - 4'd1;
               timer_nxt      = TIMER_RELOAD;
               state_nxt      = (pairs_left == 4'd1) ? DONE : FIRST;
            end else begin
               mismatch_nxt = 1'b1;
               hold_cnt_nxt = HOLD_RELOAD;
               state_nxt    = HOLD;
            end
         end
         HOLD: begin
            if (tick) begin
               hold_cnt_nxt = hold_cnt - 4'd1;
               if (hold_cnt == 4'd1) begin
                  turn_nxt  = ~turn;
                  timer_nxt = TIMER_RELOAD;
                  state_nxt = FIRST;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      flip_ready_nxt = (state_nxt == FIRST) || (state_nxt == SECOND);
      game_over_nxt  = (state_nxt == DONE);
   end

endmodule

// File: tb/tb_match_turn_controller.sv
// Bench for match_turn_controller: fixed vector table, directed multi-cycle
// sequences and randomized play, all checked against a game-level model.
module tb_match_turn_controller;

   localparam int TURN = 9;
   localparam int HOLD = 2;
   localparam int NP   = 8;
   localparam int SW   = 4;
`ifdef MATCH_BONUS_EN
   localparam int INC  = 2;
`else
   localparam int INC  = 1;
`endif

   logic          clock = 1'b0;
   logic          reset_n, start, tick, flip_valid;
   logic [3:0]    flip_index, flip_value;
   logic          flip_ready, turn;
   logic [SW-1:0] p1_score, p2_score;
   logic [3:0]    timer, pairs_left;
   logic          match_pulse, mismatch_pulse, timeout_pulse, game_over;

   match_turn_controller dut (
      .clock(clock), .reset_n(reset_n), .start(start), .tick(tick),
      .flip_valid(flip_valid), .flip_index(flip_index), .flip_value(flip_value),
      .flip_ready(flip_ready), .turn(turn), .p1_score(p1_score),
      .p2_score(p2_score), .timer(timer), .pairs_left(pairs_left),
      .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
      .timeout_pulse(timeout_pulse), .game_over(game_over)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // ---------------- game-level reference model ----------------
   int m_playing, m_over, m_turn, m_timer, m_pairs, m_hold;
   int m_mp, m_mm, m_to;
   int m_score[2];
   int q_idx[$];
   int q_val[$];

   task automatic model_reset();
      m_playing = 0; m_over = 0; m_turn = 0; m_timer = 0; m_pairs = NP;
      m_hold = 0; m_mp = 0; m_mm = 0; m_to = 0;
      m_score[0] = 0; m_score[1] = 0;
      q_idx.delete(); q_val.delete();
   endtask

   task automatic model_step(input int s, input int t, input int fv, input int fi, input int fval);
      int nt, gain;
      bit acc;
      m_mp = 0; m_mm = 0; m_to = 0;
      if (!m_playing) begin
         if (s != 0) begin
            m_score[0] = 0; m_score[1] = 0; m_pairs = NP; m_turn = 0;
            m_timer = TURN; m_playing = 1; m_over = 0; m_hold = 0;
            q_idx.delete(); q_val.delete();
         end
      end else if (m_hold > 0) begin
         // mismatched pair stays face up until the hold runs out
         if (t != 0) begin
            m_hold--;
            if (m_hold == 0) begin
               m_turn = 1 - m_turn; m_timer = TURN;
               q_idx.delete(); q_val.delete();
            end
         end
      end else if (q_idx.size() == 2) begin
         if (q_val[0] == q_val[1]) begin
            gain = 1;
`ifdef MATCH_BONUS_EN
            if (m_timer >= (TURN + 1) / 2) gain = 2;
`endif
            m_score[m_turn] = (m_score[m_turn] + gain) % (1 << SW);
            m_pairs--; m_mp = 1; m_timer = TURN;
            q_idx.delete(); q_val.delete();
            if (m_pairs == 0) begin m_playing = 0; m_over = 1; end
         end else begin
            m_mm = 1; m_hold = HOLD;
         end
      end else begin
         acc = (fv != 0) && !(q_idx.size() == 1 && fi == q_idx[0]);
         nt  = (t != 0) ? m_timer - 1 : m_timer;
         if (acc && q_idx.size() == 1) begin
            q_idx.push_back(fi); q_val.push_back(fval); m_timer = nt;
         end else if (t != 0 && nt == 0) begin
            m_to = 1; m_turn = 1 - m_turn; m_timer = TURN;
            q_idx.delete(); q_val.delete();
         end else begin
            if (acc) begin q_idx.push_back(fi); q_val.push_back(fval); end
            m_timer = nt;
         end
      end
   endtask

   task automatic compare_model(input int cyc);
      chk("m_turn",       cyc, turn,           m_turn);
      chk("m_timer",      cyc, timer,          m_timer);
      chk("m_p1",         cyc, p1_score,       m_score[0]);
      chk("m_p2",         cyc, p2_score,       m_score[1]);
      chk("m_pairs",      cyc, pairs_left,     m_pairs);
      chk("m_match",      cyc, match_pulse,    m_mp);
      chk("m_mismatch",   cyc, mismatch_pulse, m_mm);
      chk("m_timeout",    cyc, timeout_pulse,  m_to);
      chk("m_ready",      cyc, flip_ready,     (m_playing != 0 && q_idx.size() < 2) ? 1 : 0);
      chk("m_over",       cyc, game_over,      m_over);
   endtask

   int cyc = 0;

   // One clock: drive, edge, sample 1 time unit later, advance model, compare
   task automatic step(input logic rn, input logic s, input logic t, input logic fv,
                       input logic [3:0] fi, input logic [3:0] fval);
      reset_n = rn; start = s; tick = t; flip_valid = fv;
      flip_index = fi; flip_value = fval;
      @(posedge clock);
      #1;
      if (!rn) model_reset();
      else model_step(int'(s), int'(t), int'(fv), int'(fi), int'(fval));
      compare_model(cyc);
      cyc++;
   endtask

   task automatic idle(); step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0); endtask
   task automatic tk();   step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0); endtask
   task automatic flip(input logic [3:0] fi, input logic [3:0] fval);
      step(1'b1, 1'b0, 1'b0, 1'b1, fi, fval);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic s, t, fv;
      logic [3:0] fi, fval;
      int turn, timer, p1, p2, pairs, mp, mm, to, rdy, over;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic s, input logic t, input logic fv,
                               input logic [3:0] fi, input logic [3:0] fval,
                               input int tu, input int ti, input int p1, input int p2,
                               input int pa, input int mp, input int mm, input int to,
                               input int rdy, input int ov);
      vec_t v;
      v.s = s; v.t = t; v.fv = fv; v.fi = fi; v.fval = fval;
      v.turn = tu; v.timer = ti; v.p1 = p1; v.p2 = p2; v.pairs = pa;
      v.mp = mp; v.mm = mm; v.to = to; v.rdy = rdy; v.over = ov;
      return v;
   endfunction

   initial begin
      model_reset();
      // start + tick in IDLE: start wins, timer loads undecremented
      vecs[0]  = mk(1,1,0, 0,0, 0,9,0,  0,8, 0,0,0, 1,0);
      vecs[1]  = mk(0,0,1, 0,3, 0,9,0,  0,8, 0,0,0, 1,0);
      vecs[2]  = mk(0,0,1, 5,3, 0,9,0,  0,8, 0,0,0, 0,0);
      vecs[3]  = mk(0,0,0, 0,0, 0,9,INC,0,7, 1,0,0, 1,0);
      vecs[4]  = mk(0,0,0, 0,0, 0,9,INC,0,7, 0,0,0, 1,0);
      vecs[5]  = mk(0,0,1, 0,3, 0,9,INC,0,7, 0,0,0, 1,0);
      vecs[6]  = mk(0,0,1, 1,4, 0,9,INC,0,7, 0,0,0, 0,0);
      vecs[7]  = mk(0,0,0, 0,0, 0,9,INC,0,7, 0,1,0, 0,0);
      vecs[8]  = mk(0,1,0, 0,0, 0,9,INC,0,7, 0,0,0, 0,0);
      vecs[9]  = mk(0,0,0, 0,0, 0,9,INC,0,7, 0,0,0, 0,0);
      vecs[10] = mk(0,1,0, 0,0, 1,9,INC,0,7, 0,0,0, 1,0);
      vecs[11] = mk(0,0,1, 3,7, 1,9,INC,0,7, 0,0,0, 1,0);
      vecs[12] = mk(0,0,1, 3,9, 1,9,INC,0,7, 0,0,0, 1,0);
      vecs[13] = mk(0,1,0, 0,0, 1,8,INC,0,7, 0,0,0, 1,0);

      // reset state
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
      chk("rst_timer", 0, timer, 0);
      chk("rst_pairs", 0, pairs_left, 8);
      chk("rst_ready", 0, flip_ready, 0);
      chk("rst_over",  0, game_over, 0);

      for (int i = 0; i < 14; i++) begin
         step(1'b1, vecs[i].s, vecs[i].t, vecs[i].fv, vecs[i].fi, vecs[i].fval);
         chk("tbl_turn",     i, turn,           vecs[i].turn);
         chk("tbl_timer",    i, timer,          vecs[i].timer);
         chk("tbl_p1",       i, p1_score,       vecs[i].p1);
         chk("tbl_p2",       i, p2_score,       vecs[i].p2);
         chk("tbl_pairs",    i, pairs_left,     vecs[i].pairs);
         chk("tbl_match",    i, match_pulse,    vecs[i].mp);
         chk("tbl_mismatch", i, mismatch_pulse, vecs[i].mm);
         chk("tbl_timeout",  i, timeout_pulse,  vecs[i].to);
         chk("tbl_ready",    i, flip_ready,     vecs[i].rdy);
         chk("tbl_over",     i, game_over,      vecs[i].over);
      end

      // P2 holds card A (3/7) with timer 8: run it down to 1
      for (int i = 0; i < 7; i++) tk();
      chk("seq_timer1", 0, timer, 1);
      // second flip with the zeroing tick: flip wins, no timeout
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd7);
      chk("win_timer",   0, timer, 0);
      chk("win_timeout", 0, timeout_pulse, 0);
      chk("win_ready",   0, flip_ready, 0);
      chk("win_turn",    0, turn, 1);
      idle();
      chk("win_match", 0, match_pulse, 1);
      chk("win_p2",    0, p2_score, 1);
      chk("win_pairs", 0, pairs_left, 6);
      chk("win_reload",0, timer, 9);

      // timeout with one card up
      flip(4'd4, 4'd1);
      for (int i = 0; i < 9; i++) tk();
      chk("to_pulse", 0, timeout_pulse, 1);
      chk("to_turn",  0, turn, 0);
      chk("to_timer", 0, timer, 9);
      chk("to_ready", 0, flip_ready, 1);
      // card A was discarded: next two flips form a fresh pair
      flip(4'd6, 4'd2); flip(4'd7, 4'd2); idle();
      chk("disc_match", 0, match_pulse, 1);
      chk("disc_p1",    0, p1_score, 2 * INC);
      chk("disc_pairs", 0, pairs_left, 5);

      // finish the board
      for (int k = 0; k < 5; k++) begin
         flip(4'd8, 4'(k + 10)); flip(4'd9, 4'(k + 10)); idle();
      end
      chk("end_over",  0, game_over, 1);
      chk("end_pairs", 0, pairs_left, 0);
      chk("end_p1",    0, p1_score, 7 * INC);
      chk("end_ready", 0, flip_ready, 0);
      flip(4'd1, 4'd1);
      chk("end_refuse", 0, match_pulse, 0);
      chk("end_hold",   0, game_over, 1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      chk("rs_p1",    0, p1_score, 0);
      chk("rs_p2",    0, p2_score, 0);
      chk("rs_pairs", 0, pairs_left, 8);
      chk("rs_over",  0, game_over, 0);
      chk("rs_timer", 0, timer, 9);

      // randomized play, including mid-game starts and resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 499) != 0),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1),
              4'($urandom_range(0, 15)),
              4'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
